// File: rtl/load_pkg.sv
// load_pkg: load func3 codes, FSM encoding and func3-to-size lookup.
package load_pkg;
   localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LD = 3'd3, LBU = 3'd4, LHU = 3'd5, LWU = 3'd6;
   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
   function automatic logic supported(input logic [2:0] f3, input int bytes);
      return f3 != 3'd7 && !(bytes == 4 && (f3 == LD || f3 == LWU));
   endfunction
   // Unsupported codes degrade to a full-word load.
   function automatic logic [3:0] load_size(input logic [2:0] f3, input int bytes);
      if (!supported(f3, bytes)) return 4'(bytes);
      return f3[1:0] == 2'd0 ? 4'd1 : f3[1:0] == 2'd1 ? 4'd2 : f3[1:0] == 2'd2 ? 4'd4 : 4'd8;
   endfunction
endpackage

// File: rtl/load_extract.sv
// load_extract: pick the addressed bytes out of a two-word window and extend them.
module load_extract import load_pkg::*; #(
   parameter int W_SIZE = 32
) (
   input  logic [2*W_SIZE-1:0]         window,
   input  logic [$clog2(W_SIZE/8)-1:0] off,
   input  logic [2:0]                  func3,
   output logic [W_SIZE-1:0]           data
);
   localparam int BYTES = W_SIZE / 8;
   localparam int OW = $clog2(BYTES);
   logic sup, sgn;
   logic [3:0] size;
   logic [6:0] nbits;
   logic [2*W_SIZE-1:0] sh;
   logic [W_SIZE-1:0] field, mask, top;
   always_comb begin
      sup = supported(func3, BYTES);
      size = load_size(func3, BYTES);
      sh = window >> {(sup ? off : {OW{1'b0}}), 3'b000};
      field = sh[W_SIZE-1:0];
      nbits = {size, 3'b000};
      mask = nbits >= 7'(W_SIZE) ? '1 : (W_SIZE'(1) << nbits) - W_SIZE'(1);
      top = mask & ~(mask >> 1);
      sgn = sup && !func3[2] && |(field & top);
      data = (field & mask) | (sgn ? ~mask : '0);
   end
endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: sequential load formatter issuing one or two word reads per load.
module load_align_unit import load_pkg::*; #(
   parameter int W_SIZE      = 32,
   parameter int ADDR_W      = 16,
   parameter bit ALLOW_SPLIT = 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic [ADDR_W-1:0]                  req_addr,
   input  logic [2:0]                         req_func3,
   output logic                               mem_req_valid,
   input  logic                               mem_req_ready,
   output logic [ADDR_W-$clog2(W_SIZE/8)-1:0] mem_req_addr,
   input  logic                               mem_rsp_valid,
   input  logic [W_SIZE-1:0]                  mem_rsp_data,
   output logic                               resp_valid,
   input  logic                               resp_ready,
   output logic [W_SIZE-1:0]                  resp_data,
   output logic                               resp_misaligned
);
   localparam int BYTES = W_SIZE / 8;
   localparam int OW = $clog2(BYTES);
   localparam int WA_W = ADDR_W - OW;
   state_t state, state_nx;
   logic [WA_W-1:0] wa_q;
   logic [2:0] func3_q;
   logic [OW-1:0] off_q, off_in;
   logic [3:0] size_q, size_in;
   logic [W_SIZE-1:0] lo_q, resp_data_q, ext;
   logic [2*W_SIZE-1:0] window;
   logic resp_mis_q, split_in, split_q;
   always_comb begin
      size_in = load_size(req_func3, BYTES);
      off_in = supported(req_func3, BYTES) ? req_addr[OW-1:0] : '0;
      split_in = int'(off_in) + int'(size_in) > BYTES;
      split_q = int'(off_q) + int'(size_q) > BYTES;
      state_nx = state;
      case (state)
         IDLE:    if (req_valid) state_nx = split_in && !ALLOW_SPLIT ? RESP : REQ0;
         REQ0:    if (mem_req_ready) state_nx = WAIT0;
         WAIT0:   if (mem_rsp_valid) state_nx = split_q ? REQ1 : RESP;
         REQ1:    if (mem_req_ready) state_nx = WAIT1;
         WAIT1:   if (mem_rsp_valid) state_nx = RESP;
         RESP:    if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // Unsplit loads see a zero upper half, so one extractor covers both cases.
   assign window = state == WAIT1 ? {mem_rsp_data, lo_q} : {{W_SIZE{1'b0}}, mem_rsp_data};
   load_extract #(.W_SIZE(W_SIZE)) u_extract (
      .window(window),
      .off(off_q),
      .func3(func3_q),
      .data(ext)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wa_q <= '0;
         func3_q <= '0;
         off_q <= '0;
         size_q <= '0;
         lo_q <= '0;
         resp_data_q <= '0;
         resp_mis_q <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            wa_q <= req_addr[ADDR_W-1:OW];
            func3_q <= req_func3;
            off_q <= off_in;
            size_q <= size_in;
            resp_mis_q <= split_in && !ALLOW_SPLIT;
            resp_data_q <= '0;
         end
         if (state == WAIT0 && mem_rsp_valid) begin
            lo_q <= mem_rsp_data;
            if (!split_q) resp_data_q <= ext;
         end
         if (state == WAIT1 && mem_rsp_valid) resp_data_q <= ext;
      end
   assign req_ready = state == IDLE;
   assign mem_req_valid = state == REQ0 || state == REQ1;
   assign mem_req_addr = wa_q + WA_W'(state == REQ1);
   assign resp_valid = state == RESP;
   assign resp_data = resp_data_q;
   assign resp_misaligned = resp_mis_q;
endmodule
